// File: rtl/snail_hit_counter.sv
// Two BCD hit counters (Moore / Mealy) with a 4-digit multiplexed seven-segment scan.
// Define SNAIL_HIT_SATURATE_EN to make the counters stop at 99 instead of wrapping.
module snail_hit_counter #(
   parameter int unsigned clk_mhz = 50,
   parameter int unsigned w_digit = 8,
   parameter int unsigned scan_hz = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               moore_y,
   input  logic               mealy_y,
   input  logic               clr,
   output logic [7:0]         moore_cnt,
   output logic [7:0]         mealy_cnt,
   output logic [7:0]         abcdefgh,
   output logic [w_digit-1:0] digit
);

   localparam int unsigned scan_div = clk_mhz * 1_000_000 / scan_hz;
   localparam int unsigned scan_w   = (scan_div > 1) ? $clog2(scan_div) : 1;
   localparam logic [scan_w-1:0] scan_last = scan_w'(scan_div - 1);

`ifdef SNAIL_HIT_SATURATE_EN
   localparam bit saturate = 1'b1;
`else
   localparam bit saturate = 1'b0;
`endif

   logic [scan_w-1:0] scan_cnt;
   logic [1:0]        sel;
   logic              tick_c;
   logic [1:0]        sel_nxt_c;
   logic [3:0]        nibble_c;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      logic [7:0] r;
      r = v;
      if (saturate && v == 8'h99) begin
         r = v;
      end else if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
      end else begin
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] n);
      logic [7:0] s;
      case (n)
         4'd0:    s = 8'b1111_1100;
         4'd1:    s = 8'b0110_0000;
         4'd2:    s = 8'b1101_1010;
         4'd3:    s = 8'b1111_0010;
         4'd4:    s = 8'b0110_0110;
         4'd5:    s = 8'b1011_0110;
         4'd6:    s = 8'b1011_1110;
         4'd7:    s = 8'b1110_0000;
         4'd8:    s = 8'b1111_1110;
         4'd9:    s = 8'b1111_0110;
         default: s = 8'b0000_0000;
      endcase
      return s;
   endfunction

   // Hit counters: clear wins over any hit in the same cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         moore_cnt <= 8'h00;
         mealy_cnt <= 8'h00;
      end else if (clr) begin
         moore_cnt <= 8'h00;
         mealy_cnt <= 8'h00;
      end else begin
         if (en && moore_y) moore_cnt <= bcd_inc(moore_cnt);
         if (en && mealy_y) mealy_cnt <= bcd_inc(mealy_cnt);
      end
   end

   // Display is built from the next sel so digit and segments switch with sel
   always_comb begin
      tick_c    = (scan_cnt == scan_last);
      sel_nxt_c = tick_c ? sel + 2'd1 : sel;
      nibble_c  = 4'd0;
      case (sel_nxt_c)
         2'd0:    nibble_c = moore_cnt[3:0];
         2'd1:    nibble_c = moore_cnt[7:4];
         2'd2:    nibble_c = mealy_cnt[3:0];
         default: nibble_c = mealy_cnt[7:4];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         sel      <= 2'd0;
         digit    <= w_digit'(1);
         abcdefgh <= 8'b1111_1100;
      end else begin
         scan_cnt <= tick_c ? '0 : scan_cnt + scan_w'(1);
         sel      <= sel_nxt_c;
         digit    <= w_digit'(1) << sel_nxt_c;
         abcdefgh <= seg7(nibble_c);
      end
   end

endmodule

// File: doc/snail_hit_counter.md
# snail_hit_counter

Downstream stage of the snail sequence-recognizer pair. It counts strobe-qualified detections from the Moore and Mealy recognizers in two independent 2-digit BCD counters and shows both counts on the dynamic seven-segment display. Moore count goes on digits 1..0 and Mealy count on digits 3..2, time-multiplexed. It replaces the static per-FSM segment pattern in the lab top level.

## Interface
Parameters:
- `clk_mhz`, 50, clock frequency in MHz.
- `w_digit`, 8, number of display digit enables; must be ≥ 4.
- `scan_hz`, 1000, digit advance rate in Hz. `scan_div = clk_mhz*1_000_000/scan_hz` must be ≥ 2.

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous, active-low reset.
- `en`, in, 1, one-cycle strobe from the strobe generator; recognizer outputs are sampled only when `en`=1.
- `moore_y`, in, 1, Moore recognizer output.
- `mealy_y`, in, 1, Mealy recognizer output.
- `clr`, in, 1, synchronous clear of both counters.
- `moore_cnt`, out, 8, BCD Moore count {tens, ones}.
- `mealy_cnt`, out, 8, BCD Mealy count {tens, ones}.
- `abcdefgh`, out, 8, segments, active-high, a = bit 7, h (dp) = bit 0.
- `digit`, out, `w_digit`, one-hot digit enable, active-high.

## Operation
- Hit: `en & moore_y` increments `moore_cnt`; `en & mealy_y` increments `mealy_cnt`. The two counters are independent, and both may increment in the same cycle.
- BCD increment: ones 0..9. Ones 9 → 0 with tens +1. Count 99 → 00 (wrap).
- `clr`=1 forces both counts to 00 and overrides any simultaneous hit.
- Scan divider: `scan_cnt` runs 0..`scan_div`-1. `tick` is asserted when `scan_cnt` = `scan_div`-1, and `scan_cnt` then returns to 0.
- Digit index `sel` is a 2-bit value cycling 0→1→2→3→0, advancing on `tick`.
- Nibble mapping: sel 0 = moore ones, 1 = moore tens, 2 = mealy ones, 3 = mealy tens.
- Segment encoding (dp always 0):
  - 0 = 1111_1100, 1 = 0110_0000, 2 = 1101_1010, 3 = 1111_0010, 4 = 0110_0110
  - 5 = 1011_0110, 6 = 1011_1110, 7 = 1110_0000, 8 = 1111_1110, 9 = 1111_0110
- `digit` = `1 << sel`. Bits `w_digit`-1..4 are always 0.
- No leading-zero blanking.

## Timing
- Reset values (`rst`=0, asynchronous):
  - `moore_cnt` = `mealy_cnt` = 8'h00.
  - `scan_cnt` = 0, `sel` = 0.
  - `digit` = 'b1, `abcdefgh` = 8'b1111_1100.
- Count latency: the counter reflects a hit on the clock edge that samples `en`=1; it is visible one cycle after the strobe cycle.
- `abcdefgh` and `digit` are registered. They are reloaded from the current `sel` and counts every cycle, so a count change is shown no later than the cycle after it occurs while that digit is selected.
- The `sel` change and the matching `digit`/`abcdefgh` change appear together, one cycle after `tick`. No cycle may show the new digit with the old nibble.
- Hit while `en`=0: ignored, regardless of `moore_y`/`mealy_y` level.
- Reset deassertion mid-scan: scanning restarts at `sel`=0 with a full `scan_div` period.

## Configuration
- `SNAIL_HIT_SATURATE_EN` defined: each counter saturates at 99, and further hits leave it at 99 until `clr` or reset.
- `SNAIL_HIT_SATURATE_EN` undefined: 99 wraps to 00 (default behaviour).
- `clr` behaviour is identical in both builds.

## Test plan
Use `clk_mhz`=1 and `scan_hz`=250000 (`scan_div`=4) unless noted.
- Reset check: hold `rst`=0, then release. Expect counts 00/00, `digit`=1, `abcdefgh`=1111_1100, and `sel` advancing every 4 cycles.
- Gated counting: `moore_y`=1 for 20 cycles with 3 `en` pulses; `mealy_y`=1 on 2 of those pulses only. Expect `moore_cnt`=8'h03 and `mealy_cnt`=8'h02.
- BCD carry: 10 Moore hits, then 99 Mealy hits. Expect `moore_cnt`=8'h10 and `mealy_cnt`=8'h99. A further Mealy hit gives 8'h00 in the wrap build, or stays 8'h99 with `SNAIL_HIT_SATURATE_EN`.
- Clear priority: `clr`=1 in the same cycle as `en` & `moore_y` & `mealy_y`, with counts 8'h42/8'h17. Expect both counts 8'h00 next cycle.
- Scan mapping: counts 8'h37 (Moore) / 8'h05 (Mealy). Over one scan cycle expect:
  - `digit`=0001 with 1110_0000 (7)
  - `digit`=0010 with 1111_0010 (3)
  - `digit`=0100 with 1011_0110 (5)
  - `digit`=1000 with 1111_1100 (0)
- Async reset mid-operation: assert `rst`=0 between clock edges while counts are nonzero and `sel`=2. Expect all outputs at reset values immediately, before the next edge.
